// File: rtl/image_stride_fifo_reader.sv
// image_stride_fifo_reader: drains the image stride FIFO one row per burst,
// optionally keeps only even rows/columns, and streams kept words downstream.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin-frame pulse (ignored while busy)
//   col_num, row_num         frame geometry, sampled on accepted start
//   stride_en                1 = stride-2 decimation, sampled on start
//   fifo_dout/empty/m_rdy    FIFO read data, empty flag, registered M_Ready
//   fifo_rd_en, M_count      FIFO read strobe, words required per burst
//   m_data/valid/ready/last  output stream with backpressure
//   busy, done               frame in progress, end-of-frame pulse
module image_stride_fifo_reader #(
    parameter int WIDTH     = 256,
    parameter int ADDR_BITS = 11,
    parameter int ROW_BITS  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS:0]   col_num,
    input  logic [ROW_BITS-1:0]  row_num,
    input  logic                 stride_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 fifo_empty,
    input  logic                 fifo_m_rdy,
    output logic                 fifo_rd_en,
    output logic [ADDR_BITS:0]   M_count,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROW,
        READ_ROW,
        GAP,
        FLUSH
    } state_e;

    state_e              state_q;
    logic [ADDR_BITS:0]  col_q;
    logic [ADDR_BITS:0]  col_cnt_q;
    logic [ROW_BITS-1:0] row_q;
    logic [ROW_BITS-1:0] row_cnt_q;
    logic                stride_q;
    logic                busy_q;
    logic                done_q;
    logic                gap_q;
    logic                infl_q;
    logic                infl_last_q;

    logic [WIDTH-1:0]    data0_q;
    logic [WIDTH-1:0]    data1_q;
    logic                last0_q;
    logic                last1_q;
    logic [1:0]          occ_q;

    logic [ADDR_BITS:0]  col_m1;
    logic [ADDR_BITS:0]  last_col;
    logic [ROW_BITS-1:0] row_m1;
    logic [ROW_BITS-1:0] last_row;
    logic                pop;
    logic                keep_now;
    logic                last_now;
    logic                space;
    logic                rd_en;
    logic                col_end;
    logic                row_end;
    logic                flush_ok;

    assign col_m1   = col_q - 1'b1;
    assign row_m1   = row_q - 1'b1;
    // With decimation the last kept index is the largest even one.
    assign last_col = stride_q ? {col_m1[ADDR_BITS:1], 1'b0} : col_m1;
    assign last_row = stride_q ? {row_m1[ROW_BITS-1:1], 1'b0} : row_m1;

    assign col_end  = (col_cnt_q == col_m1);
    assign row_end  = (row_cnt_q == row_m1);
    assign keep_now = !stride_q || (!row_cnt_q[0] && !col_cnt_q[0]);
    assign last_now = keep_now && (row_cnt_q == last_row)
                      && (col_cnt_q == last_col);

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = data0_q;
    assign m_last   = m_valid && last0_q;
    assign pop      = m_valid && m_ready;

    // Skid slots plus the kept read in flight must fit in two entries;
    // a pop this cycle frees a slot, which sustains one word per cycle.
    assign space    = ({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
    // Discarded words never land in the skid, so they need no room.
    assign rd_en    = (state_q == READ_ROW) && !fifo_empty
                      && (!keep_now || space);
    assign flush_ok = !infl_q && ((occ_q == 2'd0) || (occ_q == 2'd1 && pop));

    assign fifo_rd_en = rd_en;
    assign M_count    = busy_q ? col_q : '0;
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            stride_q    <= 1'b0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gap_q       <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            infl_q      <= rd_en && keep_now;
            infl_last_q <= rd_en && last_now;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (col_num == '0 || row_num == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            col_q     <= col_num;
                            row_q     <= row_num;
                            stride_q  <= stride_en;
                            col_cnt_q <= '0;
                            row_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= WAIT_ROW;
                        end
                    end
                end
                WAIT_ROW: begin
                    if (fifo_m_rdy) state_q <= READ_ROW;
                end
                READ_ROW: begin
                    if (rd_en) begin
                        if (col_end) begin
                            col_cnt_q <= '0;
                            row_cnt_q <= row_cnt_q + 1'b1;
                            gap_q     <= 1'b0;
                            state_q   <= row_end ? FLUSH : GAP;
                        end else begin
                            col_cnt_q <= col_cnt_q + 1'b1;
                        end
                    end
                end
                // M_Ready lags reads by two cycles, so it is stale here.
                GAP: begin
                    gap_q <= 1'b1;
                    if (gap_q) state_q <= WAIT_ROW;
                end
                FLUSH: begin
                    if (flush_ok) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            case ({infl_q, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        data0_q <= fifo_dout;
                        last0_q <= infl_last_q;
                    end else begin
                        data1_q <= fifo_dout;
                        last1_q <= infl_last_q;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    data0_q <= data1_q;
                    last0_q <= last1_q;
                    occ_q   <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        data0_q <= fifo_dout;
                        last0_q <= infl_last_q;
                    end else begin
                        data0_q <= data1_q;
                        last0_q <= last1_q;
                        data1_q <= fifo_dout;
                        last1_q <= infl_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_image_stride_fifo_reader.sv
// tb_image_stride_fifo_reader: FIFO model plus scoreboard around the reader.
// Directed frames: pass-through, stride-2, backpressure, gating, reset.
module tb_image_stride_fifo_reader;

    localparam int W  = 32;
    localparam int AB = 11;
    localparam int RB = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AB:0]   col_num = '0;
    logic [RB-1:0] row_num = '0;
    logic          stride_en = 1'b0;
    logic [W-1:0]  fifo_dout;
    logic          fifo_empty;
    logic          fifo_m_rdy;
    logic          fifo_rd_en;
    logic [AB:0]   M_count;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    image_stride_fifo_reader #(
        .WIDTH(W), .ADDR_BITS(AB), .ROW_BITS(RB)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .col_num(col_num), .row_num(row_num), .stride_en(stride_en),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_m_rdy(fifo_m_rdy), .fifo_rd_en(fifo_rd_en),
        .M_count(M_count), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
    );

    logic [W-1:0] mem [0:255];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    logic         hold = 1'b0;
    logic         rdy1, rdy2;
    logic         bp = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_m_rdy = rdy2;

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= 0;
            rdy1      <= 1'b0;
            rdy2      <= 1'b0;
            fifo_dout <= '0;
        end else begin
            if (fifo_rd_en && !fifo_empty) begin
                fifo_dout <= mem[rd_ptr % 256];
                rd_ptr    <= rd_ptr + 1;
            end
            rdy1 <= !hold && (M_count != '0)
                    && ((wr_ptr - rd_ptr) >= int'(M_count));
            rdy2 <= rdy1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) m_ready = 1'b1;
        else     m_ready = bp ? !m_ready : 1'b1;
    end

    int           n_assert = 0;
    int           n_fail = 0;
    logic [W:0]   exp_q [$];
    int           cyc = 0;
    int           rd_cnt = 0;
    int           rd_hist [0:63];
    int           n_done = 0;
    int           done_cyc = 0;
    int           xfer_cyc = 0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] data_prev;
    logic [W:0]   mon_e;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                if (rd_cnt < 64) rd_hist[rd_cnt] = cyc;
                rd_cnt++;
            end
            if (stall_prev)
                chk("stall_hold", {m_valid, m_data}, {1'b1, data_prev});
            if (m_valid && m_ready) begin
                mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : {(W+1){1'bx}};
                chk("word", {m_last, m_data}, mon_e);
                xfer_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            stall_prev = m_valid && !m_ready;
            data_prev  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fifo(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 256] = W'(base + i);
            wr_ptr++;
        end
    endtask

    task automatic expect_frame(input int col, input int row,
                                input bit stride, input int base);
        int nk;
        int k;
        logic [W:0] e;
        nk = stride ? ((col + 1) / 2) * ((row + 1) / 2) : col * row;
        k  = 0;
        for (int r = 0; r < row; r++)
            for (int c = 0; c < col; c++)
                if (!stride || (r % 2 == 0 && c % 2 == 0)) begin
                    e = {(k == nk - 1), W'(base + r * col + c)};
                    exp_q.push_back(e);
                    k++;
                end
    endtask

    task automatic start_frame(input int col, input int row, input bit s);
        col_num   = AB'(col);
        row_num   = RB'(row);
        stride_en = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(tag, seen, 1);
        repeat (3) tick();
    endtask

    task automatic wait_rd(input int n, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (rd_cnt >= n) seen = 1'b1;
        end
        chk(tag, seen, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_mcount"}, M_count, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic end_frame(input string tag, input int reads);
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_reads"}, rd_cnt, reads);
        chk({tag, "_done_once"}, n_done, 1);
        chk({tag, "_idle"}, {busy, M_count}, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check_reset("rst");
        rst = 1'b0;
        tick();

        load_fifo(0, 8);
        expect_frame(4, 2, 0, 0);
        rd_cnt = 0;
        n_done = 0;
        start_frame(4, 2, 0);
        chk("t1_busy", busy, 1);
        chk("t1_mcount", M_count, 4);
        start_frame(0, 5, 0);
        chk("t5_busy_ignore", M_count, 4);
        wait_done("t1_done");
        end_frame("t1", 8);
        chk("t1_done_lat", done_cyc - xfer_cyc, 1);
        chk("t1_gap", rd_hist[4] - rd_hist[3], 4);

        load_fifo(0, 15);
        expect_frame(5, 3, 1, 0);
        rd_cnt = 0;
        n_done = 0;
        start_frame(5, 3, 1);
        wait_done("t2_done");
        end_frame("t2", 15);
        chk("t2_done_lat", done_cyc - xfer_cyc, 1);

        bp = 1'b1;
        load_fifo(0, 8);
        expect_frame(4, 2, 0, 0);
        rd_cnt = 0;
        n_done = 0;
        start_frame(4, 2, 0);
        wait_done("t3_done");
        end_frame("t3", 8);
        bp = 1'b0;

        load_fifo(200, 4);
        expect_frame(4, 2, 0, 200);
        rd_cnt = 0;
        n_done = 0;
        start_frame(4, 2, 0);
        wait_rd(4, "t4_row0");
        hold = 1'b1;
        tick();
        load_fifo(204, 4);
        repeat (20) tick();
        chk("t4_gated", rd_cnt, 4);
        chk("t4_busy", busy, 1);
        hold = 1'b0;
        wait_done("t4_done");
        end_frame("t4", 8);
        chk("t4_gap_long", (rd_hist[4] - rd_hist[3]) > 20, 1);

        rd_cnt = 0;
        n_done = 0;
        start_frame(0, 3, 0);
        chk("t5_col0_done", done, 1);
        chk("t5_col0_busy", busy, 0);
        tick();
        chk("t5_col0_pulse", done, 0);
        start_frame(3, 0, 1);
        chk("t5_row0_done", done, 1);
        tick();
        chk("t5_reads", rd_cnt, 0);
        chk("t5_done_cnt", n_done, 2);

        load_fifo(0, 15);
        expect_frame(5, 3, 1, 0);
        rd_cnt = 0;
        start_frame(5, 3, 1);
        wait_rd(7, "t6_row1");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check_reset("t6");
        wr_ptr = 0;
        exp_q.delete();
        rst = 1'b0;
        repeat (3) tick();
        chk("t6_quiet", {m_valid, busy, fifo_rd_en}, 0);

        load_fifo(50, 8);
        expect_frame(4, 2, 0, 50);
        rd_cnt = 0;
        n_done = 0;
        start_frame(4, 2, 0);
        wait_done("t6_recover_done");
        end_frame("t6_recover", 8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
